// File: rtl/i2s_stereo_receiver.sv
// i2s_stereo_receiver
//
// I2S master receiver. It divides the system clock into a bit clock and a
// word select, and shifts the codec's serial data MSB-first into one shift
// register per channel. It presents each completed frame to the consumer as
// a left/right pair through a valid/ready handshake. A frame that completes
// while a pair is still pending is dropped, and this is flagged with a
// one-cycle overrun pulse.
//
// Parameters
//   CLK_DIV     : clk_in cycles per sclk period (even, >= 4)
//   SLOT_BITS   : sclk periods per channel slot (frame = 2*SLOT_BITS)
//   SAMPLE_BITS : bits captured per slot (1 .. SLOT_BITS-1)
//   OUT_BITS    : output width, MSBs of the captured sample
//   STEREO      : 1 = left and right captured, 0 = left only
//
// Ports
//   clk_in         in   system clock, rising edge
//   rst_in         in   synchronous active-high reset
//   sdata_in       in   serial data from the codec
//   sclk_out       out  generated bit clock
//   ws_out         out  word select, 0 = left slot, 1 = right slot
//   left_out       out  left sample [OUT_BITS]
//   right_out      out  right sample [OUT_BITS], 0 when STEREO=0
//   data_valid_out out  left_out/right_out pair pending
//   data_ready_in  in   consumer accepts the pair when valid && ready
//   overrun_out    out  one-cycle pulse when a completed frame is dropped
module i2s_stereo_receiver #(
  parameter int CLK_DIV     = 36,
  parameter int SLOT_BITS   = 32,
  parameter int SAMPLE_BITS = 24,
  parameter int OUT_BITS    = 16,
  parameter int STEREO      = 1
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic                sdata_in,
  output logic                sclk_out,
  output logic                ws_out,
  output logic [OUT_BITS-1:0] left_out,
  output logic [OUT_BITS-1:0] right_out,
  output logic                data_valid_out,
  input  logic                data_ready_in,
  output logic                overrun_out
);

  localparam int DW = $clog2(CLK_DIV);
  localparam int BW = $clog2(2 * SLOT_BITS);

  localparam logic [DW-1:0] DIV_LAST    = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] DIV_RISE    = DW'(CLK_DIV / 2 - 1);
  localparam logic [DW-1:0] DIV_DONE    = DW'(CLK_DIV / 2);
  localparam logic [BW-1:0] BIT_LAST    = BW'(2 * SLOT_BITS - 1);
  localparam logic [BW-1:0] RIGHT_SLOT  = BW'(SLOT_BITS);
  localparam logic [BW-1:0] LEFT_FIRST  = BW'(1);
  localparam logic [BW-1:0] LEFT_LAST   = BW'(SAMPLE_BITS);
  localparam logic [BW-1:0] RIGHT_FIRST = BW'(SLOT_BITS + 1);
  localparam logic [BW-1:0] RIGHT_LAST  = BW'(SLOT_BITS + SAMPLE_BITS);
  // The frame is complete once the last captured channel has its LSB.
  localparam logic [BW-1:0] DONE_BIT    = (STEREO != 0) ? RIGHT_LAST : LEFT_LAST;

  logic [DW-1:0]          div_cnt;
  logic [BW-1:0]          bit_cnt;
  logic [BW-1:0]          bit_next;
  logic [SAMPLE_BITS-1:0] left_sr;
  logic [SAMPLE_BITS-1:0] right_sr;
  logic                   div_last;
  logic                   div_rise;
  logic                   frame_done;
  logic                   take_left;
  logic                   take_right;

  // Capture happens on the clk_in edge that raises sclk. Because of the
  // one-bit I2S delay, the MSB sits in slot bit 1, not in slot bit 0.
  always_comb begin
    div_last   = (div_cnt == DIV_LAST);
    div_rise   = (div_cnt == DIV_RISE);
    bit_next   = (bit_cnt == BIT_LAST) ? '0 : bit_cnt + BW'(1);
    take_left  = div_rise && (bit_cnt >= LEFT_FIRST) && (bit_cnt <= LEFT_LAST);
    take_right = (STEREO != 0) && div_rise &&
                 (bit_cnt >= RIGHT_FIRST) && (bit_cnt <= RIGHT_LAST);
    frame_done = (div_cnt == DIV_DONE) && (bit_cnt == DONE_BIT);
  end

  // Reset parks the counters on their last value. The first clock after
  // release therefore wraps both counters to 0 and drops sclk, so the first
  // frame starts at once. The handshake never touches the timing.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      div_cnt        <= DIV_LAST;
      bit_cnt        <= BIT_LAST;
      sclk_out       <= 1'b1;
      ws_out         <= 1'b0;
      left_sr        <= '0;
      right_sr       <= '0;
      left_out       <= '0;
      right_out      <= '0;
      data_valid_out <= 1'b0;
      overrun_out    <= 1'b0;
    end else begin
      div_cnt <= div_last ? '0 : div_cnt + DW'(1);

      if (div_rise) begin
        sclk_out <= 1'b1;
      end else if (div_last) begin
        sclk_out <= 1'b0;
      end

      if (div_last) begin
        bit_cnt <= bit_next;
        ws_out  <= (bit_next >= RIGHT_SLOT);
      end

      if (take_left) begin
        left_sr <= (left_sr << 1) | SAMPLE_BITS'(sdata_in);
      end
      if (take_right) begin
        right_sr <= (right_sr << 1) | SAMPLE_BITS'(sdata_in);
      end

      // A completion that coincides with an accept replaces the old pair
      // and keeps valid high. A completion while a pair is still pending
      // and not accepted is dropped, and an overrun pulse is raised.
      overrun_out <= 1'b0;
      if (frame_done) begin
        if (!data_valid_out || data_ready_in) begin
          left_out       <= left_sr[SAMPLE_BITS-1 -: OUT_BITS];
          right_out      <= right_sr[SAMPLE_BITS-1 -: OUT_BITS];
          data_valid_out <= 1'b1;
        end else begin
          overrun_out <= 1'b1;
        end
      end else if (data_valid_out && data_ready_in) begin
        data_valid_out <= 1'b0;
      end
    end
  end

endmodule

// File: doc/i2s_stereo_receiver.md
I2S_STEREO_RECEIVER -- requirements
Module: i2s_stereo_receiver

Interface
REQ-001 SHALL have parameter CLK_DIV, default 36: clk_in cycles per sclk period; even, >= 4.
REQ-002 SHALL have parameter SLOT_BITS, default 32: sclk periods per channel slot; frame = 2*SLOT_BITS.
REQ-003 SHALL have parameter SAMPLE_BITS, default 24: bits captured per slot; 1 <= SAMPLE_BITS <= SLOT_BITS-1.
REQ-004 SHALL have parameter OUT_BITS, default 16: output width, the MSBs of the sample; OUT_BITS <= SAMPLE_BITS.
REQ-005 SHALL have parameter STEREO, default 1: 1 = left and right captured, 0 = left only.
REQ-006 SHALL have port clk_in, input, 1: single system clock; all logic on its rising edge.
REQ-007 SHALL have port rst_in, input, 1: synchronous, active-high reset.
REQ-008 SHALL have port sdata_in, input, 1: I2S serial data from the codec.
REQ-009 SHALL have port sclk_out, output, 1: generated bit clock.
REQ-010 SHALL have port ws_out, output, 1: word select; 0 = left slot, 1 = right slot.
REQ-011 SHALL have port left_out, output, OUT_BITS: left sample.
REQ-012 SHALL have port right_out, output, OUT_BITS: right sample; 0 when STEREO=0.
REQ-013 SHALL have port data_valid_out, output, 1: the left_out/right_out pair is pending.
REQ-014 SHALL have port data_ready_in, input, 1: consumer accepts the pair when data_ready_in and data_valid_out are both 1.
REQ-015 SHALL have port overrun_out, output, 1: one-cycle pulse when a completed frame is dropped.

Function
REQ-016 SHALL keep a divider counter div 0..CLK_DIV-1, incremented every clk_in and wrapping at CLK_DIV-1.
REQ-017 SHALL set sclk_out=1 when div==CLK_DIV/2-1 and sclk_out=0 when div==CLK_DIV-1 (registered).
REQ-018 SHALL keep a bit counter bit 0..2*SLOT_BITS-1, advanced only when div==CLK_DIV-1, wrapping to 0.
REQ-019 SHALL drive ws_out=0 while bit < SLOT_BITS and ws_out=1 otherwise, updated on the same edge that bit changes.
REQ-020 SHALL shift sdata_in MSB-first into the left shift register when div==CLK_DIV/2-1 and 1 <= bit <= SAMPLE_BITS (one-bit I2S delay).
REQ-021 SHALL shift sdata_in into the right shift register when div==CLK_DIV/2-1 and SLOT_BITS+1 <= bit <= SLOT_BITS+SAMPLE_BITS, only if STEREO=1.
REQ-022 SHALL ignore sdata_in in all other slot bits.
REQ-023 SHALL define frame completion as div==CLK_DIV/2 with bit==SLOT_BITS+SAMPLE_BITS (STEREO=1) or bit==SAMPLE_BITS (STEREO=0), i.e. one clk_in after the last capture.
REQ-024 On completion, SHALL load left_out/right_out from bits [SAMPLE_BITS-1 : SAMPLE_BITS-OUT_BITS] of each shift register (truncation, no rounding), one register stage, and set data_valid_out=1.
REQ-025 SHALL hold data_valid_out and the outputs stable until a cycle with data_valid_out && data_ready_in; data_valid_out then clears on the next edge unless REQ-026 applies.
REQ-026 On completion with data_valid_out && data_ready_in in the same cycle: the old pair counts as accepted, the new pair loads, and data_valid_out stays 1 with no overrun.
REQ-027 On completion with data_valid_out=1 && data_ready_in=0: the new pair is discarded, the outputs keep the old pair, and overrun_out=1 for exactly one cycle.
REQ-028 SHALL keep overrun_out=0 in all other cycles.
REQ-029 data_ready_in SHALL have no effect while data_valid_out=0.
REQ-030 The sclk/ws timing SHALL be free-running and independent of data_ready_in.

Reset
REQ-031 While rst_in=1, SHALL set sclk_out=1, ws_out=0, data_valid_out=0, overrun_out=0, left_out=0, right_out=0, shift registers=0, div=CLK_DIV-1, bit=2*SLOT_BITS-1.
REQ-032 SHALL, in the first cycle after rst_in falls, wrap div and bit to 0 and drive sclk_out=0, so the first frame starts immediately.
REQ-033 Reset asserted mid-frame SHALL discard partial samples, any pending pair and any overrun, with no valid or overrun pulse for the aborted frame.

Verification
REQ-034 Defaults, ready held 1; left sample 0xABCDEF, right 0x123456 driven per REQ-020/021 -> left_out=0xABCD, right_out=0x1234, data_valid_out high 1 cycle, exactly one clk_in after the right LSB capture.
REQ-035 Defaults, after reset -> sclk_out period 36 clk_in with 18 high/18 low; ws_out low 32 sclk, high 32 sclk; frame = 2304 clk_in.
REQ-036 ready held 0 across two frames (0x111111/0x222222 then 0x333333/0x444444) -> outputs stay 0x1111/0x2222, valid stays 1, overrun_out one-cycle pulse at second completion.
REQ-037 ready pulsed 1 exactly in the completion cycle with a pair pending -> new pair loads, valid stays 1, overrun_out=0.
REQ-038 STEREO=0, SAMPLE_BITS=16, OUT_BITS=8, left 0x8001 -> left_out=0x80, right_out=0, valid at bit==16 completion; right-slot data ignored.
REQ-039 rst_in pulsed at bit==40 of a frame -> no valid or overrun for that frame; all outputs at reset values; next full frame captured correctly.
